// File: rtl/serv_arb_pkg.sv
// serv_arb_pkg: shared state, grant encoding and defaults for the bus arbiter
package serv_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, IBUS = 2'd1, DBUS = 2'd2} state_t;
    typedef enum logic {GNT_IBUS = 1'b0, GNT_DBUS = 1'b1} grant_t;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W = 16;
endpackage

// File: rtl/serv_arb_wdog.sv
// serv_arb_wdog: counts unacknowledged granted cycles and flags the forced-completion cycle
module serv_arb_wdog
    import serv_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // clear on grant entry, advance on every granted cycle still waiting for the memory
    always_comb cnt_d = i_clr ? '0 : i_en ? cnt_q + CNT_W'(1) : cnt_q;
    // counter register
    always_ff @(posedge clk) begin
        if (!i_rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign o_expire = i_en & (cnt_q == LIMIT);
endmodule

// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: round-robin arbiter sharing one memory port between SERV ibus and dbus
module serv_bus_arbiter
    import serv_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    output logic [3:0]  o_mem_sel,
    output logic        o_mem_we,
    output logic        o_mem_cyc,
    input  logic [31:0] i_mem_rdt,
    input  logic        i_mem_ack,
    output logic        o_timeout,
    output logic        o_busy
);
    state_t state_q, state_d;
    grant_t last_q, last_d;
    logic   to_q, to_d;
    logic   ibus_g, dbus_g, gnt_cyc, fire;
    assign ibus_g  = state_q == IBUS;
    assign dbus_g  = state_q == DBUS;
    assign gnt_cyc = (ibus_g & i_ibus_cyc) | (dbus_g & i_dbus_cyc);
    serv_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_clr    ((state_q == IDLE) & (state_d != IDLE)),
        .i_en     (gnt_cyc & ~i_mem_ack),
        .o_expire (fire)
    );
    // arbitration: a tie goes to the bus not granted last; any completion or abort returns to IDLE
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        to_d    = to_q | fire;
        if (state_q == IDLE) begin
            if (i_ibus_cyc & i_dbus_cyc) state_d = (last_q == GNT_IBUS) ? DBUS : IBUS;
            else if (i_ibus_cyc) state_d = IBUS;
            else if (i_dbus_cyc) state_d = DBUS;
            if (state_d != IDLE) last_d = (state_d == IBUS) ? GNT_IBUS : GNT_DBUS;
        end else if (i_mem_ack | fire | ~gnt_cyc) begin
            state_d = IDLE;
        end
    end
    // state, last grant and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= GNT_IBUS;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            to_q    <= to_d;
        end
    end
    // shared-port mux and per-bus responses; a forced completion acks with zero data
    always_comb begin
        o_mem_adr  = ibus_g ? i_ibus_adr : dbus_g ? i_dbus_adr : '0;
        o_mem_dat  = dbus_g ? i_dbus_dat : '0;
        o_mem_sel  = ibus_g ? 4'hF : dbus_g ? i_dbus_sel : '0;
        o_mem_we   = dbus_g & i_dbus_we;
        o_mem_cyc  = gnt_cyc;
        o_ibus_ack = ibus_g & (i_mem_ack | fire);
        o_dbus_ack = dbus_g & (i_mem_ack | fire);
        o_ibus_rdt = (ibus_g & ~fire) ? i_mem_rdt : '0;
        o_dbus_rdt = (dbus_g & ~fire) ? i_mem_rdt : '0;
        o_timeout  = to_q;
        o_busy     = state_q != IDLE;
    end
endmodule

// File: doc/serv_bus_arbiter.md
SERV_BUS_ARBITER -- requirements
Module: serv_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: number of granted cycles without i_mem_ack before a forced completion (legal range 2..65535).
REQ-002 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock for all state
- i_rst_n  in  1  synchronous active-low reset
- i_ibus_adr  in  32  instruction fetch address
- i_ibus_cyc  in  1  instruction request
- o_ibus_rdt  out  32  instruction read data
- o_ibus_ack  out  1  instruction completion
- i_dbus_adr  in  32  data address
- i_dbus_dat  in  32  write data
- i_dbus_sel  in  4  byte enables
- i_dbus_we  in  1  write enable
- i_dbus_cyc  in  1  data request
- o_dbus_rdt  out  32  data read data
- o_dbus_ack  out  1  data completion
- o_mem_adr / o_mem_dat  out  32 / 32  shared port address / write data
- o_mem_sel  out  4  shared port byte enables
- o_mem_we / o_mem_cyc  out  1 / 1  shared port write enable / request
- i_mem_rdt  in  32  shared port read data
- i_mem_ack  in  1  shared port completion
- o_timeout  out  1  sticky: a forced completion has occurred
- o_busy  out  1  state is not IDLE

Function
REQ-004 The FSM SHALL have three states: IDLE, IBUS and DBUS. All transitions SHALL be registered.
REQ-005 IDLE transitions:
- only i_ibus_cyc -> IBUS
- only i_dbus_cyc -> DBUS
- both asserted -> the bus not granted last (round-robin)
- last-grant flag resets to IBUS, so DBUS wins the first tie.
REQ-006 Grant latency SHALL be one cycle: o_mem_cyc rises the cycle after the request is sampled in IDLE.
REQ-007 Shared-port drive:
- IDLE: o_mem_* all 0.
- IBUS: o_mem_adr=i_ibus_adr, o_mem_sel=4'hF, o_mem_we=0, o_mem_dat=0, o_mem_cyc=i_ibus_cyc.
- DBUS: o_mem_* taken from the i_dbus_* signals, o_mem_cyc=i_dbus_cyc.
REQ-008 Ack and read data:
- o_X_ack = i_mem_ack & (state==X), combinational, zero added latency.
- o_X_rdt = i_mem_rdt while granted, else 0.
REQ-009 A granted state SHALL return to IDLE on the cycle after any of: i_mem_ack, forced completion, or the granted requester's cyc deasserting (abort). An abort SHALL NOT produce an ack.
REQ-010 The timeout counter SHALL clear on entry to IBUS/DBUS and increment on each granted cycle without i_mem_ack.
REQ-011 When the counter equals TIMEOUT-1 without i_mem_ack, the block SHALL force completion:
- the granted requester gets a one-cycle ack with rdt=0
- o_mem_cyc drops next cycle
- o_timeout sets.
REQ-012 If i_mem_ack and the timeout coincide, the memory ack SHALL win: real rdt is returned and o_timeout is not set by that event.
REQ-013 The ungranted requester SHALL never see ack, and a request held through another bus's transaction SHALL be granted after one IDLE cycle.
REQ-014 o_timeout SHALL be cleared only by reset.

Reset
REQ-015 On a clk edge with i_rst_n=0, the block SHALL set: state=IDLE, counter=0, last-grant=IBUS, o_timeout=0. Consequently all o_mem_*, acks, rdt and o_busy read 0 in the following cycle.
REQ-016 A reset mid-transaction SHALL abandon it with no ack issued.

Structure
REQ-017 Shared package serv_arb_pkg SHALL hold the state enumeration (IDLE/IBUS/DBUS), the grant encoding and the TIMEOUT default.
REQ-018 The timeout counter with clear/enable/expire SHALL be the sub-module serv_arb_wdog; the FSM and muxes SHALL stay in serv_bus_arbiter.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ibus fetch: i_ibus_cyc=1, adr=0x100, mem ack 3 cycles after o_mem_cyc, rdt=0x00000013 -> o_ibus_ack one cycle, o_ibus_rdt=0x13, o_mem_sel=4'hF, o_dbus_ack stays 0.
- tie: both cyc asserted in IDLE after reset -> DBUS granted first; after completion, with ibus still pending, IBUS granted after one IDLE cycle.
- dbus write: adr=0x2000, dat=0xDEADBEEF, sel=4'b0011, we=1 -> o_mem_* match exactly; ack returns; state back to IDLE.
- timeout: TIMEOUT=8, no mem ack -> o_dbus_ack pulses on the 8th granted cycle with rdt=0, o_timeout=1 and stays 1; mem ack on the 8th cycle instead -> o_timeout stays 0.
- abort/reset: i_ibus_cyc drops while granted -> IDLE next cycle, no ack; i_rst_n=0 mid-DBUS -> all outputs 0 next cycle and last-grant=IBUS.
